// File: rtl/if_tracker_mo.sv
// if_tracker_mo: instruction-fetch tracker for multiple outstanding requests.
// It snoops the IF-stage memory handshake and builds one record per fetched
// instruction. Each record holds the address, the instruction word and three
// timestamps: IF start, memory start and response.
//   clk, rst (async, active-low)
//   if_busy/if_ready             : IF-stage activity, starts the IF timestamp
//   instr_req/addr/grant         : request side; a grant queues a pending entry
//   instr_rvalid/rdata           : in-order responses; each retires one entry
//   counter                      : free-running timestamp source
//   trace_* / trace_ready        : FWFT record FIFO with a valid/ready drain
//   outstanding                  : pending-queue occupancy
//   drop_count                   : saturating count of records lost to a full FIFO
//   proto_err                    : sticky; set by a grant while full or by rvalid while empty
module if_tracker_mo #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TIME_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned OUT_DEPTH       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   if_busy,
  input  logic                                   if_ready,
  input  logic                                   instr_req,
  input  logic [ADDR_WIDTH-1:0]                  instr_addr,
  input  logic                                   instr_grant,
  input  logic                                   instr_rvalid,
  input  logic [DATA_WIDTH-1:0]                  instr_rdata,
  input  logic [TIME_WIDTH-1:0]                  counter,
  output logic                                   trace_valid,
  input  logic                                   trace_ready,
  output logic [ADDR_WIDTH-1:0]                  trace_addr,
  output logic [DATA_WIDTH-1:0]                  trace_instr,
  output logic [TIME_WIDTH-1:0]                  trace_if_start,
  output logic [TIME_WIDTH-1:0]                  trace_mem_start,
  output logic [TIME_WIDTH-1:0]                  trace_end,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic [15:0]                            drop_count,
  output logic                                   proto_err
);

  localparam int unsigned PPW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OPW    = $clog2(OUT_DEPTH);
  localparam int unsigned PCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OCNT_W = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REQ} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [TIME_WIDTH-1:0] if_start;
    logic [TIME_WIDTH-1:0] mem_start;
  } pend_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
    logic [TIME_WIDTH-1:0] if_start;
    logic [TIME_WIDTH-1:0] mem_start;
    logic [TIME_WIDTH-1:0] t_end;
  } rec_t;

  state_e                state_q, state_d;
  logic [TIME_WIDTH-1:0] if_start_q, if_start_d;
  logic [TIME_WIDTH-1:0] mem_start_q, mem_start_d;
  pend_t                 pend_q [MAX_OUTSTANDING];
  pend_t                 pend_d [MAX_OUTSTANDING];
  logic [PPW-1:0]        pwr_q, pwr_d, prd_q, prd_d;
  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  rec_t                  omem_q [OUT_DEPTH];
  rec_t                  omem_d [OUT_DEPTH];
  logic [OPW-1:0]        owr_q, owr_d, ord_q, ord_d;
  logic [OCNT_W-1:0]     ocnt_q, ocnt_d;
  logic [15:0]           drop_q, drop_d;
  logic                  err_q, err_d;

  logic  activity, push_req, pend_full, pend_empty, push_en, pop_en;
  logic  push_store, pop_queue, out_pop, out_push;
  pend_t push_ent, pop_ent;
  rec_t  rec, head;

  always_comb begin
    state_d     = state_q;
    if_start_d  = if_start_q;
    mem_start_d = mem_start_q;
    pend_d      = pend_q;
    pwr_d       = pwr_q;
    prd_d       = prd_q;
    pcnt_d      = pcnt_q;
    omem_d      = omem_q;
    owr_d       = owr_q;
    ord_d       = ord_q;
    ocnt_d      = ocnt_q;
    drop_d      = drop_q;
    err_d       = err_q;

    activity   = if_busy | if_ready;
    push_req   = instr_req & instr_grant;
    pend_full  = (pcnt_q == PCNT_W'(MAX_OUTSTANDING));
    pend_empty = (pcnt_q == '0);
    push_en    = push_req & ~pend_full;

    // A grant in the first request cycle uses this cycle's counter for
    // both timestamps that IDLE/ARMED would otherwise latch.
    push_ent.addr      = instr_addr;
    push_ent.if_start  = (state_q == S_IDLE) ? counter : if_start_q;
    push_ent.mem_start = (state_q == S_REQ) ? mem_start_q : counter;

    unique case (state_q)
      S_IDLE: if (activity) begin
        if_start_d = counter;
        if (instr_req) begin
          mem_start_d = counter;
          state_d     = S_REQ;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: if (instr_req) begin
        mem_start_d = counter;
        state_d     = S_REQ;
      end
      default: ;
    endcase

    // The memory accepted the request even if the queue cannot hold it, so
    // the FSM always moves on from the grant.
    if (push_req) begin
      if (activity) begin
        if_start_d = counter;
        state_d    = S_ARMED;
      end else begin
        state_d = S_IDLE;
      end
    end

    // A response to a request granted in the same cycle as an empty queue
    // bypasses the storage entirely.
    pop_en     = instr_rvalid & (~pend_empty | push_en);
    pop_ent    = pend_empty ? push_ent : pend_q[prd_q];
    push_store = push_en & ~(pop_en & pend_empty);
    pop_queue  = pop_en & ~pend_empty;

    if (push_store) begin
      pend_d[pwr_q] = push_ent;
      pwr_d = (pwr_q == PPW'(MAX_OUTSTANDING - 1)) ? '0 : pwr_q + 1'b1;
    end
    if (pop_queue)
      prd_d = (prd_q == PPW'(MAX_OUTSTANDING - 1)) ? '0 : prd_q + 1'b1;
    unique case ({push_store, pop_queue})
      2'b10:   pcnt_d = pcnt_q + 1'b1;
      2'b01:   pcnt_d = pcnt_q - 1'b1;
      default: ;
    endcase

    if ((push_req & pend_full) | (instr_rvalid & ~pop_en))
      err_d = 1'b1;

    rec.addr      = pop_ent.addr;
    rec.instr     = instr_rdata;
    rec.if_start  = pop_ent.if_start;
    rec.mem_start = pop_ent.mem_start;
    rec.t_end     = counter;

    // When the FIFO is full, a same-cycle consumer pop frees the slot that
    // is being written.
    out_pop  = (ocnt_q != '0) & trace_ready;
    out_push = pop_en & ((ocnt_q != OCNT_W'(OUT_DEPTH)) | out_pop);

    if (pop_en & ~out_push & (drop_q != '1))
      drop_d = drop_q + 1'b1;

    if (out_push) begin
      omem_d[owr_q] = rec;
      owr_d = (owr_q == OPW'(OUT_DEPTH - 1)) ? '0 : owr_q + 1'b1;
    end
    if (out_pop)
      ord_d = (ord_q == OPW'(OUT_DEPTH - 1)) ? '0 : ord_q + 1'b1;
    unique case ({out_push, out_pop})
      2'b10:   ocnt_d = ocnt_q + 1'b1;
      2'b01:   ocnt_d = ocnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      if_start_q  <= '0;
      mem_start_q <= '0;
      pend_q      <= '{default: '0};
      pwr_q       <= '0;
      prd_q       <= '0;
      pcnt_q      <= '0;
      omem_q      <= '{default: '0};
      owr_q       <= '0;
      ord_q       <= '0;
      ocnt_q      <= '0;
      drop_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_start_q  <= if_start_d;
      mem_start_q <= mem_start_d;
      pend_q      <= pend_d;
      pwr_q       <= pwr_d;
      prd_q       <= prd_d;
      pcnt_q      <= pcnt_d;
      omem_q      <= omem_d;
      owr_q       <= owr_d;
      ord_q       <= ord_d;
      ocnt_q      <= ocnt_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    trace_valid     = (ocnt_q != '0);
    head            = trace_valid ? omem_q[ord_q] : '0;
    trace_addr      = head.addr;
    trace_instr     = head.instr;
    trace_if_start  = head.if_start;
    trace_mem_start = head.mem_start;
    trace_end       = head.t_end;
    outstanding     = pcnt_q;
    drop_count      = drop_q;
    proto_err       = err_q;
  end

endmodule

// File: tb/tb_if_tracker_mo.sv
module tb_if_tracker_mo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_busy = 1'b0, if_ready = 1'b0;
  logic        instr_req = 1'b0, instr_grant = 1'b0, instr_rvalid = 1'b0;
  logic [31:0] instr_addr = '0, instr_rdata = '0, counter = '0;
  logic        trace_valid, trace_ready = 1'b0;
  logic [31:0] trace_addr, trace_instr, trace_if_start, trace_mem_start, trace_end;
  logic [2:0]  outstanding;
  logic [15:0] drop_count;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_tracker_mo #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIME_WIDTH(32),
    .MAX_OUTSTANDING(4), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .if_busy(if_busy), .if_ready(if_ready),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_grant(instr_grant),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .counter(counter),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_instr(trace_instr), .trace_if_start(trace_if_start),
    .trace_mem_start(trace_mem_start), .trace_end(trace_end),
    .outstanding(outstanding), .drop_count(drop_count), .proto_err(proto_err)
  );

  // One cycle: inputs set before the call are sampled at this edge; the
  // counter then advances so it reads N for the whole of cycle N.
  task automatic tick();
    @(posedge clk);
    #1;
    counter = counter + 1;
  endtask

  task automatic do_grant(input logic [31:0] a);
    instr_req = 1'b1; instr_grant = 1'b1; instr_addr = a;
    tick();
    instr_req = 1'b0; instr_grant = 1'b0;
  endtask

  task automatic do_rvalid(input logic [31:0] d);
    instr_rvalid = 1'b1; instr_rdata = d;
    tick();
    instr_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if ({trace_valid, outstanding, drop_count, proto_err} !== 21'd0) begin
      failures++; $display("FAIL reset_status got v=%b o=%0d d=%0d e=%b exp all 0", trace_valid, outstanding, drop_count, proto_err); end
    checks++; if ({trace_addr, trace_instr, trace_if_start, trace_mem_start, trace_end} !== 160'd0) begin
      failures++; $display("FAIL reset_fields got %h %h %h %h %h exp 0", trace_addr, trace_instr, trace_if_start, trace_mem_start, trace_end); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    trace_ready = 1'b1;
    counter = 10; if_ready = 1'b1;
    tick();
    if_ready = 1'b0; instr_req = 1'b1; instr_addr = 32'h80;
    tick();
    instr_grant = 1'b1;
    tick();
    instr_req = 1'b0; instr_grant = 1'b0;
    checks++; if (outstanding !== 3'd1) begin
      failures++; $display("FAIL single_outstanding got %0d exp 1", outstanding); end
    tick();
    checks++; if (trace_valid !== 1'b0) begin
      failures++; $display("FAIL single_early_valid got %b exp 0", trace_valid); end
    do_rvalid(32'h13);
    checks++; if (trace_valid !== 1'b1 || trace_addr !== 32'h80 || trace_instr !== 32'h13) begin
      failures++; $display("FAIL single_record got v=%b a=%h i=%h exp v=1 a=80 i=13", trace_valid, trace_addr, trace_instr); end
    checks++; if (trace_if_start !== 32'd10 || trace_mem_start !== 32'd11 || trace_end !== 32'd14) begin
      failures++; $display("FAIL single_times got %0d/%0d/%0d exp 10/11/14", trace_if_start, trace_mem_start, trace_end); end
    checks++; if (outstanding !== 3'd0) begin
      failures++; $display("FAIL single_retire got %0d exp 0", outstanding); end
    tick();
    checks++; if (trace_valid !== 1'b0) begin
      failures++; $display("FAIL single_drained got %b exp 0", trace_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ifs [4];
    exp_ifs[0] = 100; exp_ifs[1] = 100; exp_ifs[2] = 101; exp_ifs[3] = 102;
    counter = 100; if_busy = 1'b1;
    instr_req = 1'b1; instr_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_addr = 32'(4 * i);
      tick();
    end
    instr_req = 1'b0; instr_grant = 1'b0; if_busy = 1'b0;
    checks++; if (outstanding !== 3'd4) begin
      failures++; $display("FAIL b2b_outstanding got %0d exp 4", outstanding); end
    for (int i = 0; i < 4; i++) begin
      instr_rvalid = 1'b1; instr_rdata = 32'h1000 + 32'(i);
      tick();
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== 32'(4 * i) || trace_instr !== 32'h1000 + 32'(i) ||
          trace_end !== 32'(104 + i) || trace_mem_start !== 32'(100 + i) || trace_if_start !== exp_ifs[i]) begin
        failures++;
        $display("FAIL b2b_rec%0d got v=%b a=%h i=%h ifs=%0d ms=%0d e=%0d exp v=1 a=%h i=%h ifs=%0d ms=%0d e=%0d",
                 i, trace_valid, trace_addr, trace_instr, trace_if_start, trace_mem_start, trace_end,
                 4 * i, 32'h1000 + i, exp_ifs[i], 100 + i, 104 + i);
      end
    end
    instr_rvalid = 1'b0;
    tick();
    checks++; if (trace_valid !== 1'b0 || outstanding !== 3'd0) begin
      failures++; $display("FAIL b2b_end got v=%b o=%0d exp v=0 o=0", trace_valid, outstanding); end
  endtask

  task automatic test_backpressure();
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_grant(32'h200 + 32'(4 * i));
    for (int i = 0; i < 4; i++) do_rvalid(32'hA0 + 32'(i));
    do_grant(32'h210); do_grant(32'h214);
    do_rvalid(32'hA4); do_rvalid(32'hA5);
    checks++; if (drop_count !== 16'd2 || outstanding !== 3'd0 || trace_valid !== 1'b1) begin
      failures++; $display("FAIL bp_drops got d=%0d o=%0d v=%b exp d=2 o=0 v=1", drop_count, outstanding, trace_valid); end
    tick(); tick();
    checks++; if (trace_instr !== 32'hA0 || trace_addr !== 32'h200) begin
      failures++; $display("FAIL bp_head_stable got a=%h i=%h exp a=200 i=a0", trace_addr, trace_instr); end
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (trace_valid !== 1'b1 || trace_instr !== 32'hA0 + 32'(i) || trace_addr !== 32'h200 + 32'(4 * i)) begin
        failures++; $display("FAIL bp_drain%0d got v=%b a=%h i=%h exp v=1 a=%h i=%h", i, trace_valid, trace_addr, trace_instr, 32'h200 + 4 * i, 32'hA0 + i); end
      tick();
    end
    checks++; if (trace_valid !== 1'b0) begin
      failures++; $display("FAIL bp_empty got %b exp 0", trace_valid); end
    trace_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_grant(32'h300 + 32'(4 * i));
    for (int i = 0; i < 4; i++) do_rvalid(32'hB0 + 32'(i));
    do_grant(32'h310);
    instr_rvalid = 1'b1; instr_rdata = 32'hB4; trace_ready = 1'b1;
    tick();
    instr_rvalid = 1'b0; trace_ready = 1'b0;
    checks++; if (drop_count !== 16'd2 || trace_instr !== 32'hB1) begin
      failures++; $display("FAIL fp_nodrop got d=%0d head=%h exp d=2 head=b1", drop_count, trace_instr); end
    trace_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (trace_valid !== 1'b1 || trace_instr !== 32'hB0 + 32'(i) || trace_addr !== 32'h300 + 32'(4 * i)) begin
        failures++; $display("FAIL fp_drain%0d got v=%b a=%h i=%h exp v=1 a=%h i=%h", i, trace_valid, trace_addr, trace_instr, 32'h300 + 4 * i, 32'hB0 + i); end
      tick();
    end
    checks++; if (trace_valid !== 1'b0) begin
      failures++; $display("FAIL fp_empty got %b exp 0", trace_valid); end
  endtask

  task automatic test_proto_full();
    trace_ready = 1'b1;
    checks++; if (proto_err !== 1'b0) begin
      failures++; $display("FAIL pe_clean got %b exp 0", proto_err); end
    for (int i = 0; i < 4; i++) do_grant(32'h400 + 32'(4 * i));
    do_grant(32'h410);
    checks++; if (outstanding !== 3'd4 || proto_err !== 1'b1) begin
      failures++; $display("FAIL pe_full got o=%0d e=%b exp o=4 e=1", outstanding, proto_err); end
    for (int i = 0; i < 4; i++) begin
      do_rvalid(32'hC0 + 32'(i));
      checks++; if (trace_valid !== 1'b1 || trace_addr !== 32'h400 + 32'(4 * i)) begin
        failures++; $display("FAIL pe_rec%0d got v=%b a=%h exp v=1 a=%h", i, trace_valid, trace_addr, 32'h400 + 4 * i); end
    end
    tick();
    checks++; if (trace_valid !== 1'b0 || outstanding !== 3'd0 || drop_count !== 16'd2) begin
      failures++; $display("FAIL pe_after got v=%b o=%0d d=%0d exp v=0 o=0 d=2", trace_valid, outstanding, drop_count); end
  endtask

  task automatic test_reset_midflight();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    checks++; if (proto_err !== 1'b0 || drop_count !== 16'd0) begin
      failures++; $display("FAIL rm_prereset got e=%b d=%0d exp e=0 d=0", proto_err, drop_count); end
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_grant(32'h500 + 32'(4 * i));
    do_rvalid(32'hD0);
    checks++; if (outstanding !== 3'd2 || trace_valid !== 1'b1) begin
      failures++; $display("FAIL rm_setup got o=%0d v=%b exp o=2 v=1", outstanding, trace_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({trace_valid, outstanding, drop_count, proto_err} !== 21'd0 ||
                  {trace_addr, trace_instr, trace_if_start, trace_mem_start, trace_end} !== 160'd0) begin
      failures++; $display("FAIL rm_async got v=%b o=%0d a=%h i=%h e=%0d exp all 0", trace_valid, outstanding, trace_addr, trace_instr, trace_end); end
    tick();
    rst = 1'b1;
    tick();
    do_rvalid(32'hD1);
    checks++; if (proto_err !== 1'b1 || outstanding !== 3'd0 || trace_valid !== 1'b0) begin
      failures++; $display("FAIL rm_stale_rvalid got e=%b o=%0d v=%b exp e=1 o=0 v=0", proto_err, outstanding, trace_valid); end
    tick();
    checks++; if (trace_valid !== 1'b0 || drop_count !== 16'd0) begin
      failures++; $display("FAIL rm_no_record got v=%b d=%0d exp v=0 d=0", trace_valid, drop_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_proto_full();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
